window_buffer: RTL and testbench



---
 rtl/window_buffer_pkg.sv | 8 +
 rtl/window_buffer_line_delay.sv | 18 +
 rtl/window_buffer.sv | 100 ++++++++++
 tb/tb_window_buffer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/window_buffer_pkg.sv
// window_pkg: shared pixel type and flat window tap indexing for the spatial filters
package window_pkg;
  localparam int DEF_PIX_W = 9;
  typedef logic [DEF_PIX_W-1:0] pix_t;
  function automatic int tapIdx(input int r, input int c, input int win, input int pixW);
    return (r * win + c) * pixW;
  endfunction
endpackage

// File: rtl/window_buffer_line_delay.sv
// line_delay: one-line pixel delay, single-port RAM addressed by column, read-before-write
module line_delay #(
  parameter int PIX_W = 9,
  parameter int DEPTH = 640,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             iClk27,
  input  logic             iEn,
  input  logic [AW-1:0]    iAddr,
  input  logic [PIX_W-1:0] iD,
  output logic [PIX_W-1:0] oQ
);
  logic [PIX_W-1:0] mem [DEPTH];
  assign oQ = mem[iAddr];
  // store the current pixel after the previous line's pixel at this column has been read
  always_ff @(posedge iClk27)
    if (iEn) mem[iAddr] <= iD;
endmodule

// File: rtl/window_buffer.sv
// window_buffer: raster stream to WIN x WIN sliding neighbourhood with position tracking
module window_buffer
  import window_pkg::*;
#(
  parameter int PIX_W       = 9,
  parameter int LINE_LEN    = 640,
  parameter int FRAME_LINES = 480,
  parameter int WIN         = 3
) (
  input  logic                             iClk27,
  input  logic                             iRst,
  input  logic                             iEn,
  input  logic                             iSof,
  input  logic [PIX_W-1:0]                 iRGB,
  output logic [WIN*WIN*PIX_W-1:0]         oWin,
  output logic                             oValid,
  output logic [$clog2(LINE_LEN)-1:0]      oX,
  output logic [$clog2(FRAME_LINES)-1:0]   oY,
  output logic                             oEof
);
  localparam int R  = WIN / 2;
  localparam int XW = $clog2(LINE_LEN);
  localparam int YW = $clog2(FRAME_LINES);
  localparam logic [XW-1:0] X_LAST = XW'(LINE_LEN - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(FRAME_LINES - 1);
  localparam logic [XW-1:0] X_MIN  = XW'(WIN - 1);
  localparam logic [YW-1:0] Y_MIN  = YW'(WIN - 1);
  localparam logic [XW-1:0] X_OFF  = XW'(R);
  localparam logic [YW-1:0] Y_OFF  = YW'(R);

  logic [XW-1:0] x, curX, nxtX;
  logic [YW-1:0] y, curY, nxtY;
  logic winOk, xEnd;
  logic [PIX_W-1:0] tap [WIN];
  logic [PIX_W-1:0] col [WIN][WIN];
  logic [PIX_W-1:0] colNxt [WIN][WIN];
  logic [WIN*WIN*PIX_W-1:0] winNxt;

  // tap[k] carries the pixel k lines above the current one; tap[0] is the live input
  assign tap[0] = iRGB;
  for (genvar k = 0; k < WIN - 1; k++) begin : g_line
    line_delay #(.PIX_W(PIX_W), .DEPTH(LINE_LEN)) u_line (
      .iClk27(iClk27),
      .iEn   (iEn),
      .iAddr (curX),
      .iD    (tap[k]),
      .oQ    (tap[k+1])
    );
  end

  // position of the accepted pixel, the following position, and window qualification
  always_comb begin
    curX  = iSof ? '0 : x;
    curY  = iSof ? '0 : y;
    xEnd  = curX == X_LAST;
    nxtX  = xEnd ? '0 : curX + 1'b1;
    nxtY  = xEnd ? (curY == Y_LAST ? '0 : curY + 1'b1) : curY;
    winOk = iEn && curX >= X_MIN && curY >= Y_MIN;
  end

  // next column contents: shift left, newest pixel enters at the right; row 0 is the oldest line
  always_comb begin
    winNxt = '0;
    for (int r = 0; r < WIN; r++) begin
      for (int c = 0; c < WIN - 1; c++) colNxt[r][c] = col[r][c+1];
      colNxt[r][WIN-1] = tap[WIN-1-r];
      for (int c = 0; c < WIN; c++) winNxt[tapIdx(r, c, WIN, PIX_W) +: PIX_W] = colNxt[r][c];
    end
  end

  // position counters and column shift array advance only on accepted beats
  always_ff @(posedge iClk27 or posedge iRst)
    if (iRst) begin
      x   <= '0;
      y   <= '0;
      col <= '{default: '0};
    end else if (iEn) begin
      x   <= nxtX;
      y   <= nxtY;
      col <= colNxt;
    end

  // registered window, centre and strobes; window and centre hold between valid pulses
  always_ff @(posedge iClk27 or posedge iRst)
    if (iRst) begin
      oWin   <= '0;
      oValid <= 1'b0;
      oX     <= '0;
      oY     <= '0;
      oEof   <= 1'b0;
    end else begin
      oValid <= winOk;
      oEof   <= winOk && xEnd && curY == Y_LAST;
      if (winOk) begin
        oWin <= winNxt;
        oX   <= curX - X_OFF;
        oY   <= curY - Y_OFF;
      end
    end
endmodule

// File: tb/tb_window_buffer.sv
// tb_window_buffer: randomized and directed checks of window_buffer against a frame-array model
module tb_window_buffer;
  logic iClk27 = 1'b0;
  logic iRst;
  logic enA, sofA, enB, sofB;
  logic [8:0] rgbA, rgbB;
  logic [80:0] winA;
  logic [224:0] winB;
  logic validA, validB, eofA, eofB;
  logic [2:0] xA, yA, yB;
  logic [3:0] xB;
  int checks = 0;
  int errors = 0;
  int mx[2], my[2], nValid[2], nEof[2];
  logic [8:0] pix [2][8][16];
  logic [255:0] expWin[2];

  always #5 iClk27 = ~iClk27;

  window_buffer #(.PIX_W(9), .LINE_LEN(8), .FRAME_LINES(6), .WIN(3)) dutA (
    .iClk27(iClk27), .iRst(iRst), .iEn(enA), .iSof(sofA), .iRGB(rgbA),
    .oWin(winA), .oValid(validA), .oX(xA), .oY(yA), .oEof(eofA)
  );

  window_buffer #(.PIX_W(9), .LINE_LEN(10), .FRAME_LINES(7), .WIN(5)) dutB (
    .iClk27(iClk27), .iRst(iRst), .iEn(enB), .iSof(sofB), .iRGB(rgbB),
    .oWin(winB), .oValid(validB), .oX(xB), .oY(yB), .oEof(eofB)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      mx[d] = 0;
      my[d] = 0;
      expWin[d] = '0;
    end
  endtask

  task automatic beat(input int d, input bit en, input bit sof, input logic [8:0] rgb);
    int len, lines, w, px, py, ex, ey;
    bit ev, eeof, ov, oe;
    len = d ? 10 : 8;
    lines = d ? 7 : 6;
    w = d ? 5 : 3;
    @(negedge iClk27);
    enA = (d == 0) && en;
    enB = (d == 1) && en;
    sofA = sof;
    sofB = sof;
    rgbA = rgb;
    rgbB = rgb;
    @(posedge iClk27);
    ev = 0;
    eeof = 0;
    ex = 0;
    ey = 0;
    if (en) begin
      px = sof ? 0 : mx[d];
      py = sof ? 0 : my[d];
      pix[d][py][px] = rgb;
      ev = px >= w - 1 && py >= w - 1;
      if (ev) begin
        expWin[d] = '0;
        for (int r = 0; r < w; r++)
          for (int c = 0; c < w; c++)
            expWin[d][(r * w + c) * 9 +: 9] = pix[d][py - w + 1 + r][px - w + 1 + c];
        ex = px - w / 2;
        ey = py - w / 2;
        eeof = px == len - 1 && py == lines - 1;
      end
      if (px == len - 1) begin
        mx[d] = 0;
        my[d] = py == lines - 1 ? 0 : py + 1;
      end else begin
        mx[d] = px + 1;
        my[d] = py;
      end
    end
    #1;
    ov = d ? validB : validA;
    oe = d ? eofB : eofA;
    nValid[d] += int'(ov);
    nEof[d] += int'(oe);
    chk("valid", 256'(ov), 256'(ev));
    chk("eof", 256'(oe), 256'(eeof));
    chk("win", d ? 256'(winB) : 256'(winA), expWin[d]);
    if (ev) begin
      chk("x", d ? 256'(xB) : 256'(xA), 256'(ex));
      chk("y", d ? 256'(yB) : 256'(yA), 256'(ey));
    end
  endtask

  task automatic ramp(input int d, input int from, input int upto);
    int len;
    len = d ? 10 : 8;
    for (int i = from; i <= upto; i++) beat(d, 1, i == 0, 9'((i / len) * len + i % len));
  endtask

  task automatic gapped(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      beat(d, 1, i == 0, 9'($urandom));
      beat(d, 0, 0, 9'($urandom));
    end
  endtask

  task automatic randomRun(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(0, 3) == 0) beat(d, 0, 0, 9'($urandom));
      beat(d, 1, i == 0 || $urandom_range(0, 99) == 0, 9'($urandom));
    end
  endtask

  initial begin
    iRst = 1'b1;
    enA = 0; enB = 0; sofA = 0; sofB = 0; rgbA = 0; rgbB = 0;
    modelReset();
    repeat (2) @(negedge iClk27);
    chk("rst_validA", 256'(validA), 0);
    chk("rst_winA", 256'(winA), 0);
    chk("rst_xyA", 256'({xA, yA, eofA}), 0);
    chk("rst_winB", 256'(winB), 0);
    chk("rst_xyB", 256'({validB, xB, yB, eofB}), 0);
    iRst = 1'b0;
    nValid = '{0, 0};
    nEof = '{0, 0};
    ramp(0, 0, 18);
    chk("first_valid", 256'(validA), 1);
    chk("first_x", 256'(xA), 1);
    chk("first_y", 256'(yA), 1);
    chk("first_t00", 256'(winA[0 +: 9]), 0);
    chk("first_t11", 256'(winA[36 +: 9]), 9);
    chk("first_t22", 256'(winA[72 +: 9]), 18);
    ramp(0, 19, 47);
    chk("frame_valids", 256'(nValid[0]), 24);
    chk("frame_eofs", 256'(nEof[0]), 1);
    chk("last_x", 256'(xA), 6);
    chk("last_y", 256'(yA), 4);
    chk("last_t22", 256'(winA[72 +: 9]), 47);
    nValid[0] = 0;
    gapped(0, 48);
    chk("gapped_valids", 256'(nValid[0]), 24);
    ramp(0, 0, 34);
    beat(0, 1, 1, 9'($urandom));
    nValid[0] = 0;
    for (int i = 0; i < 17; i++) beat(0, 1, 0, 9'($urandom));
    chk("sof_quiet", 256'(nValid[0]), 0);
    beat(0, 1, 0, 9'($urandom));
    chk("sof_first_x", 256'({validA, xA, yA}), 256'({1'b1, 3'd1, 3'd1}));
    randomRun(0, 150);
    ramp(0, 0, 18);
    #2 iRst = 1'b1;
    #1;
    chk("arst_valid", 256'(validA), 0);
    chk("arst_win", 256'(winA), 0);
    modelReset();
    @(negedge iClk27);
    iRst = 1'b0;
    nValid[0] = 0;
    nEof[0] = 0;
    ramp(0, 0, 18);
    chk("restart_t22", 256'({xA, yA, winA[72 +: 9]}), 256'({3'd1, 3'd1, 9'd18}));
    ramp(0, 19, 47);
    chk("restart_valids", 256'(nValid[0]), 24);
    nValid[1] = 0;
    nEof[1] = 0;
    ramp(1, 0, 44);
    chk("w5_first", 256'({validB, xB, yB}), 256'({1'b1, 4'd2, 3'd2}));
    chk("w5_t00", 256'(winB[0 +: 9]), 0);
    chk("w5_t44", 256'(winB[216 +: 9]), 44);
    ramp(1, 45, 69);
    chk("w5_valids", 256'(nValid[1]), 18);
    chk("w5_eofs", 256'(nEof[1]), 1);
    randomRun(1, 200);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
